// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS configuration controller.
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'd0,
        SQUARE = 2'd1,
        TRI    = 2'd2,
        SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_e;

    // Amplitude code for each amplitude index (one-hot scaler select)
    localparam logic [4:0] AMP_CODE [4] = '{5'd1, 5'd2, 5'd4, 5'd8};

endpackage

// File: rtl/dds_wrap_counter.sv
// Modulo-N index counter that advances by one on each step pulse and
// wraps from N-1 back to 0. Used for the waveform, amplitude and
// frequency-step shadow indices.
module dds_wrap_counter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next index: hold, increment, or wrap to zero after the last value
    always_comb begin
        value_d = value_q;
        if (step) begin
            if (value_q == W'(N - 1)) begin
                value_d = '0;
            end else begin
                value_d = value_q + W'(1);
            end
        end
    end

    // Index register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/dds_cfg_scheduler.sv
// DDS configuration scheduler. Key pulses step shadow settings for
// waveform, frequency and amplitude; the shadow is copied to the active
// outputs only after a phase-accumulator wrap, so the output never
// changes mid-period.
// Optional feature: define WRAP_TIMEOUT_EN to force a commit after
// WRAP_TMO cycles in PENDING without a phase_wrap (stalled accumulator).
module dds_cfg_scheduler
    import dds_ctrl_pkg::*;
#(
    parameter int            FW         = 32,
    parameter logic [FW-1:0] FREQ_BASE  = FW'(85899),
    parameter int            FREQ_STEPS = 8
`ifdef WRAP_TIMEOUT_EN
    ,
    parameter int            WRAP_TMO   = 1000000
`endif
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wave_key_flag,
    input  logic          freq_key_flag,
    input  logic          amp_key_flag,
    input  logic          phase_wrap,
    output logic [1:0]    wave_sel,
    output logic [FW-1:0] freq_word,
    output logic [4:0]    amplitude,
    output logic          cfg_update,
    output logic          busy
);

    localparam int FI_W = $clog2(FREQ_STEPS);

    logic            any_key;
    logic            timeout;
    logic [1:0]      wave_idx;
    logic [1:0]      amp_idx;
    logic [FI_W-1:0] freq_idx;

    logic [FW-1:0]   freq_shadow_q, freq_shadow_d;
    state_e          state_q, state_d;
    wave_e           wave_q, wave_d;
    logic [FW-1:0]   freq_word_q, freq_word_d;
    logic [4:0]      amp_q, amp_d;
    logic            cfg_update_q, cfg_update_d;

    assign any_key = wave_key_flag | freq_key_flag | amp_key_flag;

    dds_wrap_counter #(.N(4), .W(2)) u_wave_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .step  (wave_key_flag),
        .value (wave_idx)
    );

    dds_wrap_counter #(.N(4), .W(2)) u_amp_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .step  (amp_key_flag),
        .value (amp_idx)
    );

    dds_wrap_counter #(.N(FREQ_STEPS), .W(FI_W)) u_freq_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .step  (freq_key_flag),
        .value (freq_idx)
    );

    // Shadow frequency word tracks the step index by repeated addition
    always_comb begin
        freq_shadow_d = freq_shadow_q;
        if (freq_key_flag) begin
            if (freq_idx == FI_W'(FREQ_STEPS - 1)) begin
                freq_shadow_d = FREQ_BASE;
            end else begin
                freq_shadow_d = freq_shadow_q + FREQ_BASE;
            end
        end
    end

`ifdef WRAP_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(WRAP_TMO - 1);

    logic [19:0] tmo_cnt_q, tmo_cnt_d;

    // Wait counter: zero on PENDING entry, counts each cycle spent in PENDING
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == PENDING && state_d == PENDING) begin
            tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
    end

    // Wait counter register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout = (state_q == PENDING) && (tmo_cnt_q == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Commit FSM: wait for a key, then a wrap, then copy shadow to active
    always_comb begin
        state_d      = state_q;
        wave_d       = wave_q;
        freq_word_d  = freq_word_q;
        amp_d        = amp_q;
        cfg_update_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_key) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (phase_wrap || timeout) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                wave_d       = wave_e'(wave_idx);
                freq_word_d  = freq_shadow_q;
                amp_d        = AMP_CODE[amp_idx];
                cfg_update_d = 1'b1;
                state_d      = any_key ? PENDING : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow frequency word and active output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            freq_shadow_q <= FREQ_BASE;
            wave_q        <= SINE;
            freq_word_q   <= FREQ_BASE;
            amp_q         <= 5'd1;
            cfg_update_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            freq_shadow_q <= freq_shadow_d;
            wave_q        <= wave_d;
            freq_word_q   <= freq_word_d;
            amp_q         <= amp_d;
            cfg_update_q  <= cfg_update_d;
        end
    end

    assign wave_sel   = wave_q;
    assign freq_word  = freq_word_q;
    assign amplitude  = amp_q;
    assign cfg_update = cfg_update_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dds_cfg_scheduler.sv
// Self-checking bench for dds_cfg_scheduler: directed scenarios followed
// by random key/wrap traffic, all compared against a settings-level model.
// Define WRAP_TIMEOUT_EN to also exercise the forced-commit timeout.
module tb_dds_cfg_scheduler;

    localparam int          FW         = 32;
    localparam logic [31:0] FREQ_BASE  = 32'd85899;
    localparam int          FREQ_STEPS = 8;
    localparam int          TMO        = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wave_key_flag = 1'b0;
    logic        freq_key_flag = 1'b0;
    logic        amp_key_flag = 1'b0;
    logic        phase_wrap = 1'b0;
    logic [1:0]  wave_sel;
    logic [31:0] freq_word;
    logic [4:0]  amplitude;
    logic        cfg_update;
    logic        busy;

    int assertCount = 0;
    int failCount = 0;

    // Reference model: shadow and active settings as plain step numbers
    int mWave = 0, mAmp = 0, mFreq = 0;
    int aWave = 0, aAmp = 0, aFreq = 0;
    bit mPending = 0, mApply = 0, mUpdate = 0;
    int mWait = 0;

    dds_cfg_scheduler #(
        .FW         (FW),
        .FREQ_BASE  (FREQ_BASE),
        .FREQ_STEPS (FREQ_STEPS)
`ifdef WRAP_TIMEOUT_EN
        ,
        .WRAP_TMO   (TMO)
`endif
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .wave_key_flag (wave_key_flag),
        .freq_key_flag (freq_key_flag),
        .amp_key_flag  (amp_key_flag),
        .phase_wrap    (phase_wrap),
        .wave_sel      (wave_sel),
        .freq_word     (freq_word),
        .amplitude     (amplitude),
        .cfg_update    (cfg_update),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] freqOf(input int n);
        logic [31:0] r;
        r = FREQ_BASE * 32'(n + 1);
        return r;
    endfunction

    // Advance the model across one clock edge with the given inputs
    task automatic modelEdge(input bit rst, input bit wk, input bit fk, input bit ak, input bit wr);
        bit anyKey;
        bit tmoHit;
        anyKey = wk | fk | ak;
        tmoHit = 1'b0;
        if (rst) begin
            mWave = 0; mAmp = 0; mFreq = 0;
            aWave = 0; aAmp = 0; aFreq = 0;
            mPending = 0; mApply = 0; mUpdate = 0; mWait = 0;
            return;
        end
        mUpdate = mApply;
        if (mApply) begin
            aWave = mWave;
            aAmp  = mAmp;
            aFreq = mFreq;
        end
        if (wk) mWave = (mWave + 1) % 4;
        if (ak) mAmp  = (mAmp + 1) % 4;
        if (fk) mFreq = (mFreq + 1) % FREQ_STEPS;
        if (mApply) begin
            mApply   = 0;
            mPending = anyKey;
            mWait    = 0;
        end else if (mPending) begin
`ifdef WRAP_TIMEOUT_EN
            tmoHit = (mWait == TMO - 1);
`endif
            if (wr || tmoHit) begin
                mPending = 0;
                mApply   = 1;
            end else begin
                mWait = mWait + 1;
            end
        end else if (anyKey) begin
            mPending = 1;
            mWait    = 0;
        end
    endtask

    // Drive one cycle of inputs (from a negedge), step the model, return at the next negedge
    task automatic applyStimulus(input bit rst, input bit wk, input bit fk, input bit ak, input bit wr);
        sys_rst       = rst;
        wave_key_flag = wk;
        freq_key_flag = fk;
        amp_key_flag  = ak;
        phase_wrap    = wr;
        @(posedge sys_clk);
        modelEdge(rst, wk, fk, ak, wr);
        @(negedge sys_clk);
        sys_rst       = 1'b0;
        wave_key_flag = 1'b0;
        freq_key_flag = 1'b0;
        amp_key_flag  = 1'b0;
        phase_wrap    = 1'b0;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        checkVal({tag, "_wave"}, 32'(wave_sel), 32'(aWave));
        checkVal({tag, "_freq"}, freq_word, freqOf(aFreq));
        checkVal({tag, "_amp"}, 32'(amplitude), 32'(1 << aAmp));
        checkVal({tag, "_upd"}, 32'(cfg_update), 32'(mUpdate));
        checkVal({tag, "_busy"}, 32'(busy), 32'(mPending | mApply));
    endtask

    initial begin
        int upd;
        int found;
        @(negedge sys_clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset");
        checkVal("reset_freq_const", freq_word, 32'd85899);

        // Idle after reset: nothing changes
        repeat (20) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("t1_idle");
        end

        // Single amp key, wrap five cycles later
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t2_key");
        checkVal("t2_busy_const", 32'(busy), 32'd1);
        repeat (4) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("t2_wait");
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t2_wrap");
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_commit");
        checkVal("t2_amp_const", 32'(amplitude), 32'd2);
        checkVal("t2_upd_const", 32'(cfg_update), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_after");

        // Eight frequency keys wrap the step index back to step 0
        upd = 0;
        repeat (8) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("t3_key");
            upd += int'(cfg_update);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t3_wrap");
        upd += int'(cfg_update);
        repeat (3) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("t3_after");
            upd += int'(cfg_update);
        end
        checkVal("t3_freq_const", freq_word, 32'd85899);
        checkVal("t3_one_update", 32'(upd), 32'd1);

        // Simultaneous keys all land in one commit
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t4_keys");
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t4_wrap");
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_commit");
        checkVal("t4_wave_const", 32'(wave_sel), 32'd1);
        checkVal("t4_freq_const", freq_word, 32'd171798);
        checkVal("t4_amp_const", 32'(amplitude), 32'd2);

        // Key with wrap is included; key during APPLY waits for the next wrap
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t5_key");
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t5_keywrap");
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t5_applykey");
        checkVal("t5_amp_const", 32'(amplitude), 32'd4);
        checkVal("t5_busy_const", 32'(busy), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5_wrap2");
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_commit2");
        checkVal("t5_amp2_const", 32'(amplitude), 32'd8);

        // Reset while PENDING drops the pending change
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t6_pending");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_reset");
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_after");
        checkVal("t6_wave_const", 32'(wave_sel), 32'd0);
        checkVal("t6_busy_const", 32'(busy), 32'd0);

`ifdef WRAP_TIMEOUT_EN
        // No wrap: forced APPLY 16 edges after PENDING entry, outputs one edge later
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("tmo_wait");
            if (cfg_update) found = k;
        end
        checkVal("tmo_latency", 32'(found), 32'd17);
`else
        found = 0;
`endif

        // Random key/wrap traffic against the model
        applyStimulus(1, 0, 0, 0, 0);
        repeat (600) begin
            applyStimulus($urandom_range(99) == 0,
                          $urandom_range(7) == 0,
                          $urandom_range(7) == 0,
                          $urandom_range(7) == 0,
                          $urandom_range(5) == 0);
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
